// File: rtl/div_sqrt_mvp_issue_ctrl_pkg.sv
// Purpose : shared widths, state encoding and synthetic-result constants for the div/sqrt issue controller.
// Latency : n/a (definitions only).
// Backpr. : n/a (definitions only).
package defs_div_sqrt_mvp;

  // Operand / control field widths of the attached div/sqrt unit.
  localparam int C_OP_FP64 = 64;
  localparam int C_RM      = 3;
  localparam int C_PC      = 6;
  localparam int C_FS      = 2;
  localparam int C_FFLAGS  = 5;

  // Result substituted when the watchdog aborts an operation.
  localparam logic [C_OP_FP64-1:0] C_CANON_NAN = 64'h7FF8000000000000;
  localparam logic [C_FFLAGS-1:0]  C_FLAG_NV   = 5'b10000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } issue_state_e;

endpackage

// File: rtl/div_sqrt_mvp_issue_hold.sv
// Purpose : single-entry holding register for the unit result, flags and tag.
// Latency : 1 cycle from Load_SI to Out_valid_SO.
// Backpr. : contents frozen while Out_valid_SO & ~Out_ready_SI; a load always overwrites.
//
// Ports:
//   Clk_CI, Rst_RBI          clock, async active-low reset
//   Load_SI                  capture Result_DI / Fflags_SI / Tag_DI this cycle
//   Result_DI, Fflags_SI,
//   Tag_DI                   data to capture
//   Out_valid_SO/Out_ready_SI  output handshake
//   Out_result_DO, Out_fflags_SO, Out_tag_DO  held contents
module div_sqrt_mvp_issue_hold
  import defs_div_sqrt_mvp::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RBI,
  input  logic                 Load_SI,
  input  logic [C_OP_FP64-1:0] Result_DI,
  input  logic [C_FFLAGS-1:0]  Fflags_SI,
  input  logic [TAG_W-1:0]     Tag_DI,
  output logic                 Out_valid_SO,
  input  logic                 Out_ready_SI,
  output logic [C_OP_FP64-1:0] Out_result_DO,
  output logic [C_FFLAGS-1:0]  Out_fflags_SO,
  output logic [TAG_W-1:0]     Out_tag_DO
);

  logic                 valid_q;
  logic [C_OP_FP64-1:0] result_q;
  logic [C_FFLAGS-1:0]  fflags_q;
  logic [TAG_W-1:0]     tag_q;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      fflags_q <= '0;
      tag_q    <= '0;
    end else if (Load_SI) begin
      valid_q  <= 1'b1;
      result_q <= Result_DI;
      fflags_q <= Fflags_SI;
      tag_q    <= Tag_DI;
    end else if (valid_q && Out_ready_SI) begin
      // Data is left in place after consumption; only the valid bit drops.
      valid_q  <= 1'b0;
    end
  end

  assign Out_valid_SO  = valid_q;
  assign Out_result_DO = result_q;
  assign Out_fflags_SO = fflags_q;
  assign Out_tag_DO    = tag_q;

endmodule

// File: rtl/div_sqrt_mvp_issue_ctrl.sv
// Purpose : initiator-side issue controller for the shared div/sqrt unit (one op in flight, flush via Kill).
// Latency : accept in t -> start pulse in t+1; Done in d -> Out_valid in d+1.
// Backpr. : In_ready_SO low while busy, while the Ready guard runs, or while an unconsumed result is held.
//
// Optional feature macro: DIV_SQRT_ISSUE_TIMEOUT_EN (watchdog that kills a WAIT lasting
// TIMEOUT_CYCLES and returns canonical NaN with NV set).
//
// Ports:
//   Clk_CI, Rst_RBI                    clock, async active-low reset (shared with the unit)
//   In_valid_SI/In_ready_SO            request handshake
//   In_sqrt_SI, In_op_a_DI, In_op_b_DI,
//   In_rm_SI, In_prec_SI, In_fmt_SI,
//   In_tag_DI                          request contents
//   Flush_SI                           abort the in-flight op and drop its result
//   Div_start_SO, Sqrt_start_SO        one-cycle start pulses to the unit
//   Operand_a_DO, Operand_b_DO, RM_SO,
//   Precision_ctl_SO, Format_sel_SO    registered operands/control to the unit
//   Kill_SO                            one-cycle kill pulse to the unit
//   Result_DI, Fflags_SI, Ready_SI,
//   Done_SI                            unit status / result
//   Out_valid_SO/Out_ready_SI          result handshake
//   Out_result_DO, Out_fflags_SO,
//   Out_tag_DO                         held result
module div_sqrt_mvp_issue_ctrl
  import defs_div_sqrt_mvp::*;
#(
  parameter int POST_PIPE_DEPTH = 2,
  parameter int TAG_W           = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RBI,
  input  logic                 In_valid_SI,
  output logic                 In_ready_SO,
  input  logic                 In_sqrt_SI,
  input  logic [C_OP_FP64-1:0] In_op_a_DI,
  input  logic [C_OP_FP64-1:0] In_op_b_DI,
  input  logic [C_RM-1:0]      In_rm_SI,
  input  logic [C_PC-1:0]      In_prec_SI,
  input  logic [C_FS-1:0]      In_fmt_SI,
  input  logic [TAG_W-1:0]     In_tag_DI,
  input  logic                 Flush_SI,
  output logic                 Div_start_SO,
  output logic                 Sqrt_start_SO,
  output logic [C_OP_FP64-1:0] Operand_a_DO,
  output logic [C_OP_FP64-1:0] Operand_b_DO,
  output logic [C_RM-1:0]      RM_SO,
  output logic [C_PC-1:0]      Precision_ctl_SO,
  output logic [C_FS-1:0]      Format_sel_SO,
  output logic                 Kill_SO,
  input  logic [C_OP_FP64-1:0] Result_DI,
  input  logic [C_FFLAGS-1:0]  Fflags_SI,
  input  logic                 Ready_SI,
  input  logic                 Done_SI,
  output logic                 Out_valid_SO,
  input  logic                 Out_ready_SI,
  output logic [C_OP_FP64-1:0] Out_result_DO,
  output logic [C_FFLAGS-1:0]  Out_fflags_SO,
  output logic [TAG_W-1:0]     Out_tag_DO
);

  // Guard spans the unit's output pipeline plus one cycle, during which the
  // unit's Ready may still reflect the op that was just started or killed.
  localparam int                GUARD_W    = $clog2(POST_PIPE_DEPTH + 2);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(POST_PIPE_DEPTH + 1);

  if (POST_PIPE_DEPTH < 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("div_sqrt_mvp_issue_ctrl: invalid POST_PIPE_DEPTH or TIMEOUT_CYCLES");
  end

  issue_state_e         state_q;
  logic [GUARD_W-1:0]   guard_q;
  logic                 start_q;
  logic                 sqrt_q;
  logic [C_OP_FP64-1:0] op_a_q;
  logic [C_OP_FP64-1:0] op_b_q;
  logic [C_RM-1:0]      rm_q;
  logic [C_PC-1:0]      prec_q;
  logic [C_FS-1:0]      fmt_q;
  logic [TAG_W-1:0]     tag_q;

  logic                 out_vld;
  logic                 in_rdy;
  logic                 accept;
  logic                 flush_kill;
  logic                 timeout_kill;
  logic                 done_take;
  logic                 hold_load;
  logic [C_OP_FP64-1:0] hold_result;
  logic [C_FFLAGS-1:0]  hold_fflags;

`ifdef DIV_SQRT_ISSUE_TIMEOUT_EN
  localparam int               WDOG_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_q;

  // Fires in the TIMEOUT_CYCLES-th WAIT cycle; a real Done or a flush in that
  // same cycle takes precedence.
  assign timeout_kill = (state_q == WAIT) && !Flush_SI && !Done_SI && (wdog_q == WDOG_LAST);
`else
  assign timeout_kill = 1'b0;
`endif

  assign in_rdy     = (state_q == IDLE) && Ready_SI && (guard_q == '0) && (!out_vld || Out_ready_SI);
  assign accept     = In_valid_SI && in_rdy;
  assign flush_kill = Flush_SI && ((state_q == ISSUE) || (state_q == WAIT));
  // Done coinciding with a flush belongs to the op being killed and is dropped.
  assign done_take  = (state_q == WAIT) && Done_SI && !Flush_SI;

  assign hold_load   = done_take || timeout_kill;
  assign hold_result = timeout_kill ? C_CANON_NAN : Result_DI;
  assign hold_fflags = timeout_kill ? C_FLAG_NV   : Fflags_SI;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
      guard_q <= '0;
      start_q <= 1'b0;
      sqrt_q  <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      rm_q    <= '0;
      prec_q  <= '0;
      fmt_q   <= '0;
      tag_q   <= '0;
`ifdef DIV_SQRT_ISSUE_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      if (guard_q != '0) begin
        guard_q <= guard_q - 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= ISSUE;
            start_q <= 1'b1;
            sqrt_q  <= In_sqrt_SI;
            op_a_q  <= In_op_a_DI;
            op_b_q  <= In_op_b_DI;
            rm_q    <= In_rm_SI;
            prec_q  <= In_prec_SI;
            fmt_q   <= In_fmt_SI;
            tag_q   <= In_tag_DI;
          end
        end
        ISSUE: begin
          guard_q <= GUARD_LOAD;
          state_q <= Flush_SI ? FLUSH : WAIT;
`ifdef DIV_SQRT_ISSUE_TIMEOUT_EN
          wdog_q  <= '0;
`endif
        end
        WAIT: begin
          if (Flush_SI || timeout_kill) begin
            guard_q <= GUARD_LOAD;
            state_q <= FLUSH;
          end else if (Done_SI) begin
            state_q <= IDLE;
          end
`ifdef DIV_SQRT_ISSUE_TIMEOUT_EN
          else begin
            wdog_q <= wdog_q + 1'b1;
          end
`endif
        end
        FLUSH: begin
          // Leave as the guard expires so IDLE is entered with guard == 0.
          if (guard_q <= GUARD_W'(1)) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // start_q is only ever set for the ISSUE cycle; a flush in that cycle
  // suppresses the pulse so the unit never sees start and kill together.
  assign Div_start_SO     = start_q && !sqrt_q && !Flush_SI;
  assign Sqrt_start_SO    = start_q &&  sqrt_q && !Flush_SI;
  assign Kill_SO          = flush_kill || timeout_kill;
  assign In_ready_SO      = in_rdy;
  assign Operand_a_DO     = op_a_q;
  assign Operand_b_DO     = op_b_q;
  assign RM_SO            = rm_q;
  assign Precision_ctl_SO = prec_q;
  assign Format_sel_SO    = fmt_q;

  div_sqrt_mvp_issue_hold #(
    .TAG_W(TAG_W)
  ) i_hold (
    .Clk_CI        (Clk_CI),
    .Rst_RBI       (Rst_RBI),
    .Load_SI       (hold_load),
    .Result_DI     (hold_result),
    .Fflags_SI     (hold_fflags),
    .Tag_DI        (tag_q),
    .Out_valid_SO  (out_vld),
    .Out_ready_SI  (Out_ready_SI),
    .Out_result_DO (Out_result_DO),
    .Out_fflags_SO (Out_fflags_SO),
    .Out_tag_DO    (Out_tag_DO)
  );

  assign Out_valid_SO = out_vld;

endmodule
